// File: rtl/vga_ordered_dither.sv
// 4x4 ordered (Bayer) dither from IN_W to OUT_W bits per channel, two-pixel latency, CE-gated.
// Optional frame-rotating pattern: define VGA_DITHER_TEMPORAL_EN.
module vga_ordered_dither #(
    parameter int   IN_W        = 8,
    parameter int   OUT_W       = 6,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic             CLK_VIDEO,
    input  logic             RESET_N,
    input  logic             CE_PIXEL,
    input  logic             ENABLE,
    input  logic [IN_W-1:0]  R_IN,
    input  logic [IN_W-1:0]  G_IN,
    input  logic [IN_W-1:0]  B_IN,
    input  logic             HS_IN,
    input  logic             VS_IN,
    input  logic             DE_IN,
    output logic [OUT_W-1:0] VGA_R,
    output logic [OUT_W-1:0] VGA_G,
    output logic [OUT_W-1:0] VGA_B,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_DE
);

    localparam int DROP = IN_W - OUT_W;

    generate
        if (DROP < 1 || DROP > 4) begin : g_bad_drop
            $error("vga_ordered_dither: IN_W-OUT_W must be in 1..4");
        end
    endgenerate

    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    function automatic logic [3:0] bayer_thr(input logic [1:0] y, input logic [1:0] x);
        return BAYER[{y, x}] >> (4 - DROP);
    endfunction

    // Carry out of the (IN_W+1)-bit sum clamps to full scale instead of wrapping.
    function automatic logic [OUT_W-1:0] dither_sat(input logic [IN_W-1:0] c, input logic [3:0] thr);
        logic [IN_W:0] sum;
        sum = {1'b0, c} + (IN_W+1)'(thr);
        if (sum[IN_W]) return '1;
        return sum[IN_W-1:DROP];
    endfunction

    logic [1:0]      px_q, px_d, py_q, py_d;
    logic [1:0]      x_cur, x_idx, y_idx;
    logic            de_rise, de_fall, vs_start;
    logic [3:0]      thr_d, thr_p1_q;
    logic [IN_W-1:0] r_p1_q, g_p1_q, b_p1_q;
    logic            vld_p1_q, hs_p1_q, vs_p1_q;
    logic [OUT_W-1:0] vga_r_q, vga_g_q, vga_b_q;
    logic            vga_hs_q, vga_vs_q, vga_de_q;
`ifdef VGA_DITHER_TEMPORAL_EN
    logic [1:0]      frame_q, frame_d;
`endif

    // Stage-1 DE/VS registers double as the edge-detect history; they share reset value and enable.
    always_comb begin
        de_rise  = DE_IN & ~vld_p1_q;
        de_fall  = ~DE_IN & vld_p1_q;
        vs_start = (VS_IN == SYNC_ACTIVE) && (vs_p1_q != SYNC_ACTIVE);
        // px_q holds the column of the next active pixel; a DE rise forces the current one to 0.
        x_cur    = de_rise ? 2'd0 : px_q;
        px_d     = px_q;
        if (de_rise)    px_d = 2'd1;
        else if (DE_IN) px_d = px_q + 2'd1;
        py_d     = py_q;
        if (vs_start)     py_d = 2'd0;
        else if (de_fall) py_d = py_q + 2'd1;
`ifdef VGA_DITHER_TEMPORAL_EN
        frame_d  = vs_start ? frame_q + 2'd1 : frame_q;
        x_idx    = x_cur ^ frame_q;
        y_idx    = py_q ^ {frame_q[0], frame_q[1]};
`else
        x_idx    = x_cur;
        y_idx    = py_q;
`endif
        thr_d    = ENABLE ? bayer_thr(y_idx, x_idx) : 4'd0;
    end

    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            px_q     <= 2'd0;
            py_q     <= 2'd0;
`ifdef VGA_DITHER_TEMPORAL_EN
            frame_q  <= 2'd0;
`endif
            vld_p1_q <= 1'b0;
            hs_p1_q  <= ~SYNC_ACTIVE;
            vs_p1_q  <= ~SYNC_ACTIVE;
            vga_r_q  <= '0;
            vga_g_q  <= '0;
            vga_b_q  <= '0;
            vga_hs_q <= ~SYNC_ACTIVE;
            vga_vs_q <= ~SYNC_ACTIVE;
            vga_de_q <= 1'b0;
        end else if (CE_PIXEL) begin
            px_q     <= px_d;
            py_q     <= py_d;
`ifdef VGA_DITHER_TEMPORAL_EN
            frame_q  <= frame_d;
`endif
            // stage 1: control
            vld_p1_q <= DE_IN;
            hs_p1_q  <= HS_IN;
            vs_p1_q  <= VS_IN;
            // stage 2: dithered colour, blanked outside active video
            vga_r_q  <= vld_p1_q ? dither_sat(r_p1_q, thr_p1_q) : '0;
            vga_g_q  <= vld_p1_q ? dither_sat(g_p1_q, thr_p1_q) : '0;
            vga_b_q  <= vld_p1_q ? dither_sat(b_p1_q, thr_p1_q) : '0;
            vga_hs_q <= hs_p1_q;
            vga_vs_q <= vs_p1_q;
            vga_de_q <= vld_p1_q;
        end
    end

    // stage 1: colour and threshold (no reset; masked by vld_p1_q downstream)
    always_ff @(posedge CLK_VIDEO) begin
        if (CE_PIXEL) begin
            r_p1_q   <= R_IN;
            g_p1_q   <= G_IN;
            b_p1_q   <= B_IN;
            thr_p1_q <= thr_d;
        end
    end

    assign VGA_R  = vga_r_q;
    assign VGA_G  = vga_g_q;
    assign VGA_B  = vga_b_q;
    assign VGA_HS = vga_hs_q;
    assign VGA_VS = vga_vs_q;
    assign VGA_DE = vga_de_q;

endmodule
